mskaes_key_expand_engine: RTL and testbench

Self-sequenced, d-share Boolean-masked AES key-expansion engine for AES-128, AES-192 and AES-256, selected per run. It emits the full expanded key one 32-bit word per handshake: 44, 52 or 60 words. Non-linear steps go through an external shared masked Sbox column port with fixed latency. All internal operations are linear on shares, so the block needs no randomness. It sits beside the 32-bit masked round datapath as a key-word producer and replaces hard-wired AES-128/256 key-schedule control.

---
 rtl/mskaes_key_expand_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_mskaes_key_expand_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_key_expand_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mskaes_key_expand_engine
//  Description : Self-sequenced d-share Boolean-masked AES-128/192/256 key
//                expansion. Emits one shared 32-bit key word per handshake.
//                SubWord goes through an external masked Sbox with a fixed
//                latency. Every internal operation is linear on shares.
//  Revision    : 1.0  initial release
// ============================================================================
module mskaes_key_expand_engine #(
   parameter int D      = 2,
   parameter int SB_LAT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               start_ready,
   input  logic [1:0]         mode,
   input  logic [256*D-1:0]   sh_key,
   output logic               sb_valid,
   output logic [32*D-1:0]    sh_sb_out,
   input  logic [32*D-1:0]    sh_sb_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [32*D-1:0]    sh_word,
   output logic [5:0]         word_idx,
   output logic               last,
   output logic               busy
);

   localparam int W  = 32 * D;
   localparam int CW = $clog2(SB_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_EMIT_INIT = 3'd1,
      S_CALC      = 3'd2,
      S_SB_REQ    = 3'd3,
      S_SB_WAIT   = 3'd4,
      S_EMIT      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [7:0][W-1:0]  win_q, win_d;       // W[0] is the oldest word
   logic [7:0]         rcon_q, rcon_d;
   logic [5:0]         idx_q, idx_d;       // i
   logic [2:0]         pos_q, pos_d;       // i mod Nk
   logic [2:0]         nkm1_q, nkm1_d;     // Nk-1 of the current run
   logic [5:0]         last_idx_q, last_idx_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [W-1:0]       w_top;
   logic [W-1:0]       rot_top;
   logic [W-1:0]       rcon_sh;
   logic [W-1:0]       new_word;
   logic               shift_en;
   logic [2:0]         pos_next;
   logic               pos_wrap;
   logic               nonlin_cur;
   logic               nonlin_next;
   logic [2:0]         mode_nkm1;
   logic [5:0]         mode_last;
   logic [7:0]         rcon_next;

   assign w_top     = win_q[nkm1_q];
   assign pos_wrap  = (pos_q == nkm1_q);
   assign pos_next  = pos_wrap ? 3'd0 : pos_q + 3'd1;
   assign nonlin_cur  = (pos_q == 3'd0) || ((nkm1_q == 3'd7) && (pos_q == 3'd4));
   assign nonlin_next = (pos_next == 3'd0) || ((nkm1_q == 3'd7) && (pos_next == 3'd4));
   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   // RotWord on the shared word: byte m takes byte m+1, byte 3 takes byte 0
   for (genvar m = 0; m < 4; m++) begin : g_rot
      assign rot_top[8*D*m +: 8*D] = w_top[8*D*((m+1)%4) +: 8*D];
   end

   // Rcon lands in share 0 of byte 0; every other share sees zero
   for (genvar b = 0; b < 8; b++) begin : g_rcon
      assign rcon_sh[b*D +: D] = {{(D-1){1'b0}}, rcon_q[b]};
   end
   assign rcon_sh[W-1:8*D] = '0;

   // Window size and final word index implied by the requested mode
   always_comb begin
      mode_nkm1 = 3'd3;
      mode_last = 6'd43;
      case (mode)
         2'b01:   begin mode_nkm1 = 3'd5; mode_last = 6'd51; end
         2'b10:   begin mode_nkm1 = 3'd7; mode_last = 6'd59; end
         default: begin mode_nkm1 = 3'd3; mode_last = 6'd43; end
      endcase
   end

   // Sequencer: next state, window update and outputs. Non-linear steps skip
   // the CALC decision cycle so the Sbox request issues right after a word.
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      rcon_d      = rcon_q;
      idx_d       = idx_q;
      pos_d       = pos_q;
      nkm1_d      = nkm1_q;
      last_idx_d  = last_idx_q;
      cnt_d       = cnt_q;
      shift_en    = 1'b0;
      new_word    = '0;
      start_ready = 1'b0;
      sb_valid    = 1'b0;
      sh_sb_out   = '0;
      out_valid   = 1'b0;
      sh_word     = '0;
      word_idx    = 6'd0;
      last        = 1'b0;
      busy        = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start && (mode != 2'b11)) begin
               for (int k = 0; k < 8; k++) begin
                  win_d[k] = (3'(k) <= mode_nkm1) ? sh_key[W*k +: W] : '0;
               end
               nkm1_d     = mode_nkm1;
               last_idx_d = mode_last;
               idx_d      = 6'd0;
               pos_d      = 3'd0;
               rcon_d     = 8'h01;
               state_d    = S_EMIT_INIT;
            end
         end
         S_EMIT_INIT: begin
            out_valid = 1'b1;
            sh_word   = win_q[0];
            word_idx  = idx_q;
            if (out_ready) begin
               shift_en = 1'b1;          // rotate: oldest word goes to the top
               new_word = win_q[0];
               idx_d    = idx_q + 6'd1;
               pos_d    = pos_next;
               if (pos_wrap) begin
                  state_d = nonlin_next ? S_SB_REQ : S_CALC;
               end
            end
         end
         S_CALC: begin
            if (nonlin_cur) begin
               state_d = S_SB_REQ;
            end else begin
               shift_en = 1'b1;
               new_word = win_q[0] ^ w_top;
               state_d  = S_EMIT;
            end
         end
         S_SB_REQ: begin
            sb_valid  = 1'b1;
            sh_sb_out = (pos_q == 3'd0) ? rot_top : w_top;
            cnt_d     = CW'(1);
            state_d   = S_SB_WAIT;
         end
         S_SB_WAIT: begin
            if (cnt_q == CW'(SB_LAT)) begin
               shift_en = 1'b1;
               new_word = win_q[0] ^ sh_sb_in ^ ((pos_q == 3'd0) ? rcon_sh : '0);
               if (pos_q == 3'd0) begin
                  rcon_d = rcon_next;
               end
               state_d = S_EMIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            sh_word   = w_top;
            word_idx  = idx_q;
            last      = (idx_q == last_idx_q);
            if (out_ready) begin
               idx_d = idx_q + 6'd1;
               pos_d = pos_next;
               if (idx_q == last_idx_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = nonlin_next ? S_SB_REQ : S_CALC;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (shift_en) begin
         for (int k = 0; k < 7; k++) begin
            if (3'(k) < nkm1_q) begin
               win_d[k] = win_q[k+1];
            end
         end
         win_d[nkm1_q] = new_word;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         win_q      <= '0;
         rcon_q     <= 8'h01;
         idx_q      <= 6'd0;
         pos_q      <= 3'd0;
         nkm1_q     <= 3'd3;
         last_idx_q <= 6'd43;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         rcon_q     <= rcon_d;
         idx_q      <= idx_d;
         pos_q      <= pos_d;
         nkm1_q     <= nkm1_d;
         last_idx_q <= last_idx_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mskaes_key_expand_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mskaes_key_expand_engine
//  Description : Directed bench for the masked AES key-expansion engine with
//                a behavioural masked Sbox of fixed latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mskaes_key_expand_engine;

   localparam int D      = 2;
   localparam int SB_LAT = 4;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                    128'hdeadbeef0badf00d123456789abcdef0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                    64'hfeedfacecafebabe};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               start_ready;
   logic [1:0]         mode;
   logic [256*D-1:0]   sh_key;
   logic               sb_valid;
   logic [32*D-1:0]    sh_sb_out;
   logic [32*D-1:0]    sh_sb_in;
   logic               out_valid;
   logic               out_ready;
   logic [32*D-1:0]    sh_word;
   logic [5:0]         word_idx;
   logic               last;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_w   [60];
   logic [31:0] got_w   [60];
   int          got_cyc [60];
   logic [31:0] sb_col  [16];
   int          n_words;
   int          n_sb;
   int          end_rel;

   mskaes_key_expand_engine #(.D(D), .SB_LAT(SB_LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_ready (start_ready),
      .mode        (mode),
      .sh_key      (sh_key),
      .sb_valid    (sb_valid),
      .sh_sb_out   (sh_sb_out),
      .sh_sb_in    (sh_sb_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sh_word     (sh_word),
      .word_idx    (word_idx),
      .last        (last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---- GF(2^8) arithmetic for the reference Sbox ----
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);        // accumulates x^254 = x^-1
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // ---- share / recombine; byte 0 of the shared word is bits [31:24] here ----
   function automatic logic [31:0] unshare(input logic [32*D-1:0] v);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < 8; b++)
            for (int s = 0; s < D; s++)
               r[8*(3-k)+b] = r[8*(3-k)+b] ^ v[8*D*k + b*D + s];
      return r;
   endfunction

   function automatic logic [32*D-1:0] share_word(input logic [31:0] w);
      logic [32*D-1:0] v;
      logic            acc;
      logic            rb;
      v = '0;
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < 8; b++) begin
            acc = w[8*(3-k)+b];
            for (int s = 1; s < D; s++) begin
               rb = 1'($urandom_range(0, 1));
               v[8*D*k + b*D + s] = rb;
               acc = acc ^ rb;
            end
            v[8*D*k + b*D] = acc;
         end
      return v;
   endfunction

   function automatic logic [256*D-1:0] share_key(input logic [255:0] k);
      logic [256*D-1:0] r;
      for (int j = 0; j < 8; j++) r[32*D*j +: 32*D] = share_word(k[255-32*j -: 32]);
      return r;
   endfunction

   // ---- behavioural masked Sbox: fresh resharing, SB_LAT cycles latency ----
   logic [32*D-1:0] sb_pipe [0:SB_LAT-1];
   always @(posedge clk) begin
      sb_pipe[0] <= sb_valid ? share_word(subword(unshare(sh_sb_out))) : '0;
      for (int k = 1; k < SB_LAT; k++) sb_pipe[k] <= sb_pipe[k-1];
   end
   assign sh_sb_in = sb_pipe[SB_LAT-1];

   // ---- FIPS-197 key expansion reference ----
   task automatic ref_expand(input int nk, input logic [255:0] key);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = ref_w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % 8 == 4) begin
            t = subword(t);
         end
         ref_w[i] = ref_w[i-nk] ^ t;
      end
   endtask

   // One full run; cycle 0 is the accept cycle. bp = random backpressure,
   // poke = drive start/mode=00 while the run is busy.
   task automatic run_key(input logic [1:0] md, input logic [255:0] key, input bit bp, input bit poke);
      int          nk;
      int          nw;
      int          rel;
      bit          stalled;
      logic [31:0] prev_w;
      logic [5:0]  prev_i;
      nk = (md == 2'b00) ? 4 : (md == 2'b01) ? 6 : 8;
      nw = 4 * (nk + 7);
      ref_expand(nk, key);
      sh_key = share_key(key);
      n_words = 0;
      n_sb = 0;
      stalled = 1'b0;
      prev_w = '0;
      prev_i = '0;
      rel = 0;
      @(negedge clk);
      check_eq("start_ready before run", 64'(start_ready), 64'd1);
      mode  = md;
      start = 1'b1;
      while (n_words < nw && rel < 3000) begin
         @(negedge clk);
         rel++;
         start = poke && rel >= 20 && rel < 30;
         mode  = (poke && rel >= 20 && rel < 30) ? 2'b00 : md;
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sb_valid) begin
            if (n_sb < 16) sb_col[n_sb] = unshare(sh_sb_out);
            n_sb++;
         end
         if (stalled) begin
            check_eq("held word", 64'(unshare(sh_word)), 64'(prev_w));
            check_eq("held idx", 64'(word_idx), 64'(prev_i));
         end
         stalled = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               got_w[n_words]   = unshare(sh_word);
               got_cyc[n_words] = rel;
               check_eq($sformatf("word_idx %0d", n_words), 64'(word_idx), 64'(n_words));
               check_eq($sformatf("last %0d", n_words), 64'(last), 64'(n_words == nw - 1));
               check_eq($sformatf("word %0d", n_words), 64'(got_w[n_words]), 64'(ref_w[n_words]));
               n_words++;
            end else begin
               stalled = 1'b1;
               prev_w  = unshare(sh_word);
               prev_i  = word_idx;
            end
         end
      end
      if (n_words < nw) check_eq("run timeout words", 64'(n_words), 64'(nw));
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rel++;
      end_rel = rel;
      check_eq("start_ready after last", 64'(start_ready), 64'd1);
      check_eq("busy after last", 64'(busy), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n = 1'b0;
      start = 1'b0;
      mode = 2'b00;
      out_ready = 1'b1;
      sh_key = '0;
      repeat (2) @(negedge clk);
      check_eq("rst start_ready", 64'(start_ready), 64'd1);
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst out_valid", 64'(out_valid), 64'd0);
      check_eq("rst sb_valid", 64'(sb_valid), 64'd0);
      check_eq("rst sh_word", 64'(unshare(sh_word)), 64'd0);
      check_eq("rst word_idx", 64'(word_idx), 64'd0);
      rst_n = 1'b1;

      // AES-128 FIPS-197 A.1 with exact timing
      run_key(2'b00, K128, 1'b0, 1'b0);
      check_eq("aes128 w4", 64'(got_w[4]), 64'h a0fafe17);
      check_eq("aes128 w43", 64'(got_w[43]), 64'h b6630ca6);
      check_eq("aes128 w0 cycle", 64'(got_cyc[0]), 64'd1);
      check_eq("aes128 w4 cycle", 64'(got_cyc[4]), 64'd10);
      check_eq("aes128 w43 cycle", 64'(got_cyc[43]), 64'd124);
      check_eq("aes128 idle cycle", 64'(end_rel), 64'd125);
      check_eq("aes128 sb pulses", 64'(n_sb), 64'd10);
      check_eq("aes128 rotword req", 64'(sb_col[0]), 64'h cf4f3c09);

      // reserved mode is ignored
      @(negedge clk);
      mode = 2'b11;
      start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("mode11 start_ready", 64'(start_ready), 64'd1);
         check_eq("mode11 busy", 64'(busy), 64'd0);
         check_eq("mode11 out_valid", 64'(out_valid), 64'd0);
      end
      start = 1'b0;
      mode = 2'b00;

      // AES-192 FIPS-197 A.2 with start/mode poked while busy
      run_key(2'b01, K192, 1'b0, 1'b1);
      check_eq("aes192 w6", 64'(got_w[6]), 64'h fe0c91f7);
      check_eq("aes192 w51", 64'(got_w[51]), 64'h 01002202);
      check_eq("aes192 sb pulses", 64'(n_sb), 64'd8);

      // AES-256 FIPS-197 A.3
      run_key(2'b10, K256, 1'b0, 1'b0);
      check_eq("aes256 w8", 64'(got_w[8]), 64'h 9ba35411);
      check_eq("aes256 w12", 64'(got_w[12]), 64'h a8b09c1a);
      check_eq("aes256 w12 sbox req", 64'(sb_col[1]), 64'h 2067fcde);
      check_eq("aes256 w59", 64'(got_w[59]), 64'h 706c631e);
      check_eq("aes256 sb pulses", 64'(n_sb), 64'd13);

      // AES-128 under random backpressure
      run_key(2'b00, K128, 1'b1, 1'b0);
      check_eq("bp aes128 w4", 64'(got_w[4]), 64'h a0fafe17);
      check_eq("bp aes128 w43", 64'(got_w[43]), 64'h b6630ca6);
      check_eq("bp aes128 sb pulses", 64'(n_sb), 64'd10);

      // reset while waiting on the Sbox
      sh_key = share_key(K128);
      mode = 2'b00;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (sb_valid) seen = 1'b1;
         else @(negedge clk);
      end
      check_eq("reached sb request", 64'(seen), 64'd1);
      @(negedge clk);
      check_eq("busy in sb wait", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("arst start_ready", 64'(start_ready), 64'd1);
      check_eq("arst busy", 64'(busy), 64'd0);
      check_eq("arst sb_valid", 64'(sb_valid), 64'd0);
      check_eq("arst sh_sb_out", 64'(unshare(sh_sb_out)), 64'd0);
      check_eq("arst out_valid", 64'(out_valid), 64'd0);
      check_eq("arst word_idx", 64'(word_idx), 64'd0);
      check_eq("arst last", 64'(last), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_key(2'b00, K128, 1'b0, 1'b0);
      check_eq("rerun w4", 64'(got_w[4]), 64'h a0fafe17);
      check_eq("rerun w43", 64'(got_w[43]), 64'h b6630ca6);
      check_eq("rerun w4 cycle", 64'(got_cyc[4]), 64'd10);
      check_eq("rerun w43 cycle", 64'(got_cyc[43]), 64'd124);
      check_eq("rerun sb pulses", 64'(n_sb), 64'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
